// File: rtl/tea_cbc_sequencer_if.sv
// Word-stream input and block-result output handshakes of the TEA CBC front-end.
// The master side produces words and consumes results; the slave side is the sequencer.
interface tea_cbc_sequencer_if;
    logic [31:0] s_data;
    logic [1:0]  s_kind;
    logic        s_dec;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready;

    modport master (
        output s_data, s_kind, s_dec, s_valid,
        input  s_ready,
        input  m_data, m_valid,
        output m_ready
    );

    modport slave (
        input  s_data, s_kind, s_dec, s_valid,
        output s_ready,
        output m_data, m_valid,
        input  m_ready
    );
endinterface

// File: rtl/tea_cbc_sequencer.sv
// Assembles key/IV/data words into blocks, sequences the key write into tea_interface,
// and wraps the cipher with optional CBC chaining, returning registered 64-bit results.
module tea_cbc_sequencer #(
    parameter bit CBC = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    tea_cbc_sequencer_if.slave  bus,
    output logic                err,
    output logic [63:0]         tea_in,
    output logic                tea_mode,
    output logic                tea_writekey,
    input  logic [63:0]         tea_out
);
    localparam logic [1:0] KIND_DATA = 2'b00;
    localparam logic [1:0] KIND_KEY  = 2'b01;
    localparam logic [1:0] KIND_IV   = 2'b10;
    localparam logic [1:0] KIND_RSVD = 2'b11;

    typedef enum logic [2:0] {COLLECT, KEY_HI, KEY_LO, CRYPT, OUT} state_t;

    state_t      state_reg;
    logic [1:0]  cnt_reg;
    logic [1:0]  kind_reg;
    logic [95:0] asm_reg;
    logic [63:0] key_lo_reg;
    logic [63:0] iv_reg;
    logic [63:0] chain_reg;
    logic [63:0] blk_reg;
    logic [63:0] m_data_reg;
    logic [63:0] tea_in_reg;
    logic        key_ok_reg;
    logic        dec_reg;
    logic        m_valid_reg;
    logic        err_reg;
    logic        tea_mode_reg;
    logic        tea_writekey_reg;

    logic        restart;
    logic [1:0]  pos;
    logic        group_done;
    logic [63:0] word_pair;
    logic [63:0] chain_eff;
    logic [63:0] result;

    always_comb begin
        // A word of a different kind mid-group becomes word 0 of a new group.
        restart    = (cnt_reg != 2'd0) && (bus.s_kind != kind_reg);
        pos        = restart ? 2'd0 : cnt_reg;
        group_done = (bus.s_kind == KIND_KEY) ? (pos == 2'd3) : (pos == 2'd1);
        word_pair  = {asm_reg[31:0], bus.s_data};
        chain_eff  = CBC ? chain_reg : 64'd0;
        result     = dec_reg ? (tea_out ^ chain_eff) : tea_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= COLLECT;
            cnt_reg          <= 2'd0;
            kind_reg         <= KIND_DATA;
            asm_reg          <= '0;
            key_lo_reg       <= '0;
            iv_reg           <= '0;
            chain_reg        <= '0;
            blk_reg          <= '0;
            m_data_reg       <= '0;
            tea_in_reg       <= '0;
            key_ok_reg       <= 1'b0;
            dec_reg          <= 1'b0;
            m_valid_reg      <= 1'b0;
            err_reg          <= 1'b0;
            tea_mode_reg     <= 1'b0;
            tea_writekey_reg <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            unique case (state_reg)
                COLLECT: begin
                    if (bus.s_valid) begin
                        if (bus.s_kind == KIND_RSVD) begin
                            err_reg <= 1'b1;
                        end else begin
                            if (restart) err_reg <= 1'b1;
                            asm_reg  <= {asm_reg[63:0], bus.s_data};
                            kind_reg <= bus.s_kind;
                            if (bus.s_kind == KIND_DATA && pos == 2'd0) dec_reg <= bus.s_dec;
                            if (!group_done) begin
                                cnt_reg <= pos + 2'd1;
                            end else begin
                                cnt_reg <= 2'd0;
                                unique case (bus.s_kind)
                                    KIND_KEY: begin
                                        tea_in_reg       <= asm_reg[95:32];
                                        tea_writekey_reg <= 1'b1;
                                        key_lo_reg       <= word_pair;
                                        state_reg        <= KEY_HI;
                                    end
                                    KIND_IV: begin
                                        iv_reg    <= word_pair;
                                        chain_reg <= word_pair;
                                    end
                                    KIND_DATA: begin
                                        if (!key_ok_reg) begin
                                            err_reg <= 1'b1;
                                        end else begin
                                            blk_reg      <= word_pair;
                                            tea_in_reg   <= dec_reg ? word_pair : (word_pair ^ chain_eff);
                                            tea_mode_reg <= dec_reg;
                                            state_reg    <= CRYPT;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
                KEY_HI: begin
                    tea_writekey_reg <= 1'b0;
                    tea_in_reg       <= key_lo_reg;
                    state_reg        <= KEY_LO;
                end
                KEY_LO: begin
                    tea_in_reg <= '0;
                    key_ok_reg <= 1'b1;
                    chain_reg  <= iv_reg;
                    state_reg  <= COLLECT;
                end
                CRYPT: begin
                    m_data_reg   <= result;
                    m_valid_reg  <= 1'b1;
                    if (CBC) chain_reg <= dec_reg ? blk_reg : tea_out;
                    tea_in_reg   <= '0;
                    tea_mode_reg <= 1'b0;
                    state_reg    <= OUT;
                end
                OUT: begin
                    if (bus.m_ready) begin
                        m_valid_reg <= 1'b0;
                        state_reg   <= COLLECT;
                    end
                end
                default: state_reg <= COLLECT;
            endcase
        end
    end

    assign bus.s_ready  = (state_reg == COLLECT);
    assign bus.m_data   = m_data_reg;
    assign bus.m_valid  = m_valid_reg;
    assign err          = err_reg;
    assign tea_in       = tea_in_reg;
    assign tea_mode     = tea_mode_reg;
    assign tea_writekey = tea_writekey_reg;
endmodule

// File: tb/tb_tea_cbc_sequencer.sv
// Drives an ECB instance (dut 0) and a CBC instance (dut 1) against a toy invertible cipher
// standing in for tea_interface; results are checked through a per-instance expected queue.
module tb_tea_cbc_sequencer;
    localparam logic [1:0]  K_DATA = 2'b00;
    localparam logic [1:0]  K_KEY  = 2'b01;
    localparam logic [1:0]  K_IV   = 2'b10;
    localparam logic [1:0]  K_RSVD = 2'b11;
    localparam logic [63:0] KEY_H  = 64'h1234567890abcdef;
    localparam logic [63:0] KEY_L  = 64'hfedcba0987654321;
    localparam logic [63:0] PT     = 64'h1234567890abcdef;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] s_data [2];
    logic [1:0]  s_kind [2];
    logic        s_dec [2];
    logic        s_valid [2];
    logic        s_ready [2];
    logic [63:0] m_data [2];
    logic        m_valid [2];
    logic        m_ready [2];
    logic        err [2];
    logic [63:0] tea_in [2];
    logic        tea_mode [2];
    logic        tea_writekey [2];
    logic [63:0] tea_out [2];
    logic [63:0] khi [2];
    logic [63:0] klo [2];
    logic        kpend [2];
    logic        prev_valid [2];

    int total = 0;
    int bad = 0;
    logic [63:0] exp_q0 [$];
    logic [63:0] exp_q1 [$];

    function automatic logic [63:0] toy_enc(input logic [63:0] x, input logic [63:0] hi, input logic [63:0] lo);
        logic [63:0] t;
        t = x ^ hi;
        return {t[50:0], t[63:51]} + lo;
    endfunction

    function automatic logic [63:0] toy_dec(input logic [63:0] y, input logic [63:0] hi, input logic [63:0] lo);
        logic [63:0] t;
        t = y - lo;
        return {t[12:0], t[63:13]} ^ hi;
    endfunction

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            tea_cbc_sequencer_if bus ();
            assign bus.s_data  = s_data[gi];
            assign bus.s_kind  = s_kind[gi];
            assign bus.s_dec   = s_dec[gi];
            assign bus.s_valid = s_valid[gi];
            assign bus.m_ready = m_ready[gi];
            assign s_ready[gi] = bus.s_ready;
            assign m_data[gi]  = bus.m_data;
            assign m_valid[gi] = bus.m_valid;

            tea_cbc_sequencer #(.CBC(gi == 1)) u_dut (
                .clk          (clk),
                .rst_n        (rst_n),
                .bus          (bus.slave),
                .err          (err[gi]),
                .tea_in       (tea_in[gi]),
                .tea_mode     (tea_mode[gi]),
                .tea_writekey (tea_writekey[gi]),
                .tea_out      (tea_out[gi])
            );

            assign tea_out[gi] = tea_mode[gi] ? toy_dec(tea_in[gi], khi[gi], klo[gi])
                                              : toy_enc(tea_in[gi], khi[gi], klo[gi]);

            // Cipher stand-in: high key half with writekey, low half on the following cycle.
            always @(posedge clk) begin
                if (tea_writekey[gi]) begin
                    khi[gi]   <= tea_in[gi];
                    kpend[gi] <= 1'b1;
                end else if (kpend[gi]) begin
                    klo[gi]   <= tea_in[gi];
                    kpend[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic push(input int d, input logic [63:0] v);
        if (d == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    task automatic send(input int d, input logic [1:0] k, input logic [31:0] w, input logic dec);
        int n;
        n = 0;
        s_data[d]  = w;
        s_kind[d]  = k;
        s_dec[d]   = dec;
        s_valid[d] = 1'b1;
        while (!s_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready[d]) begin
            total++;
            bad++;
            $display("FAIL send_timeout dut%0d: s_ready=0 want 1", d);
        end
        @(negedge clk);
        s_valid[d] = 1'b0;
    endtask

    task automatic send_block(input int d, input logic [1:0] k, input logic [63:0] v, input logic dec);
        send(d, k, v[63:32], dec);
        send(d, k, v[31:0], dec);
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (!s_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready[d]) begin
            total++;
            bad++;
            $display("FAIL idle_timeout dut%0d: s_ready=0 want 1", d);
        end
    endtask

    task automatic load_key(input int d);
        send(d, K_KEY, 32'h12345678, 1'b0);
        send(d, K_KEY, 32'h90abcdef, 1'b0);
        send(d, K_KEY, 32'hfedcba09, 1'b0);
        send(d, K_KEY, 32'h87654321, 1'b0);
        check("key_hi_writekey", tea_writekey[d], 1'b1);
        check("key_hi_in", tea_in[d], KEY_H);
        @(negedge clk);
        check("key_lo_writekey", tea_writekey[d], 1'b0);
        check("key_lo_in", tea_in[d], KEY_L);
        check("key_lo_sready", s_ready[d], 1'b0);
        @(negedge clk);
        check("key_done_sready", s_ready[d], 1'b1);
        check("key_done_in", tea_in[d], 64'd0);
    endtask

    // Scoreboard monitor: each new result presentation pops one expected block.
    always @(negedge clk) begin : mon
        logic [63:0] e;
        int sz;
        for (int d = 0; d < 2; d++) begin
            if (m_valid[d] && !prev_valid[d]) begin
                sz = (d == 0) ? exp_q0.size() : exp_q1.size();
                total++;
                if (sz == 0) begin
                    bad++;
                    $display("FAIL unexpected_output dut%0d: got %h want none", d, m_data[d]);
                end else begin
                    if (d == 0) e = exp_q0.pop_front();
                    else        e = exp_q1.pop_front();
                    if (m_data[d] !== e) begin
                        bad++;
                        $display("FAIL result dut%0d: got %h want %h", d, m_data[d], e);
                    end else begin
                        $display("dut%0d result %h", d, m_data[d]);
                    end
                end
            end
            prev_valid[d] <= m_valid[d];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] c1, c2, cap, held, iv_b, blk;
        int n;
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = 1'b0;
            s_data[d]  = 32'd0;
            s_kind[d]  = K_DATA;
            s_dec[d]   = 1'b0;
            m_ready[d] = 1'b1;
        end
        c1 = toy_enc(PT, KEY_H, KEY_L);
        c2 = toy_enc(PT ^ c1, KEY_H, KEY_L);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_m_valid", m_valid[d], 1'b0);
            check("rst_m_data", m_data[d], 64'd0);
            check("rst_err", err[d], 1'b0);
            check("rst_tea_in", tea_in[d], 64'd0);
            check("rst_tea_writekey", tea_writekey[d], 1'b0);
            check("rst_tea_mode", tea_mode[d], 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_sready0", s_ready[0], 1'b1);
        check("rst_sready1", s_ready[1], 1'b1);

        // Data before any key is dropped with an error.
        send_block(1, K_DATA, PT, 1'b0);
        check("nokey_err", err[1], 1'b1);
        @(negedge clk);
        check("nokey_err_pulse", err[1], 1'b0);

        // ECB: key load, encrypt with latency and capture checks.
        load_key(0);
        push(0, c1);
        send_block(0, K_DATA, PT, 1'b0);
        check("lat_crypt_valid", m_valid[0], 1'b0);
        check("ecb_tea_in", tea_in[0], PT);
        check("ecb_tea_mode", tea_mode[0], 1'b0);
        cap = tea_out[0];
        @(negedge clk);
        check("lat_out_valid", m_valid[0], 1'b1);
        check("crypt_capture", m_data[0], cap);
        wait_idle(0);

        push(0, PT);
        send_block(0, K_DATA, c1, 1'b1);
        wait_idle(0);

        // Kind change mid-group: partial key discarded, data restarts at word 0.
        send(0, K_KEY, 32'hdeadbeef, 1'b0);
        send(0, K_DATA, 32'h0badf00d, 1'b0);
        check("kind_change_err", err[0], 1'b1);
        @(negedge clk);
        check("kind_change_pulse", err[0], 1'b0);
        blk = {32'h0badf00d, 32'h01234567};
        push(0, toy_enc(blk, KEY_H, KEY_L));
        send(0, K_DATA, 32'h01234567, 1'b0);
        wait_idle(0);

        send(0, K_RSVD, 32'h55555555, 1'b0);
        check("reserved_err", err[0], 1'b1);

        // ECB ignores the IV.
        send_block(0, K_IV, 64'hffff0000ffff0000, 1'b0);
        push(0, c1);
        send_block(0, K_DATA, PT, 1'b0);
        wait_idle(0);

        // CBC chaining and decrypt after IV reload.
        load_key(1);
        send_block(1, K_IV, 64'd0, 1'b0);
        push(1, c1);
        send_block(1, K_DATA, PT, 1'b0);
        wait_idle(1);
        push(1, c2);
        send_block(1, K_DATA, PT, 1'b0);
        wait_idle(1);
        send_block(1, K_IV, 64'd0, 1'b0);
        push(1, PT);
        send_block(1, K_DATA, c1, 1'b1);
        wait_idle(1);
        push(1, PT);
        send_block(1, K_DATA, c2, 1'b1);
        wait_idle(1);

        // Backpressure with a non-zero IV.
        iv_b = 64'h0f0f0f0f33cc33cc;
        send_block(1, K_IV, iv_b, 1'b0);
        push(1, toy_enc(PT ^ iv_b, KEY_H, KEY_L));
        m_ready[1] = 1'b0;
        send_block(1, K_DATA, PT, 1'b0);
        n = 0;
        while (!m_valid[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", m_valid[1], 1'b1);
        held = m_data[1];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_data_stable", m_data[1], held);
            check("bp_valid_held", m_valid[1], 1'b1);
            check("bp_sready_low", s_ready[1], 1'b0);
        end
        m_ready[1] = 1'b1;
        @(negedge clk);
        check("bp_released", m_valid[1], 1'b0);
        @(negedge clk);
        check("bp_one_transfer", m_valid[1], 1'b0);
        check("bp_sready_back", s_ready[1], 1'b1);

        // Asynchronous reset while dut 0 is in CRYPT.
        send_block(0, K_DATA, PT, 1'b0);
        check("crypt_before_reset", tea_in[0], PT);
        rst_n = 1'b0;
        #1;
        check("async_m_valid", m_valid[0], 1'b0);
        check("async_m_data", m_data[0], 64'd0);
        check("async_tea_in", tea_in[0], 64'd0);
        check("async_tea_mode", tea_mode[0], 1'b0);
        check("async_tea_writekey", tea_writekey[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_block(0, K_DATA, PT, 1'b0);
        check("post_reset_nokey_err", err[0], 1'b1);
        repeat (6) @(negedge clk);

        check("queue0_drained", 64'(exp_q0.size()), 64'd0);
        check("queue1_drained", 64'(exp_q1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tea_cbc_sequencer.md
# tea_cbc_sequencer

Upstream front-end for `tea_interface`. It accepts a 32-bit word stream carrying key, IV and data words, and assembles 64-bit blocks. It sequences the two-cycle key write into `tea_interface`, applies optional CBC chaining around the cipher, and returns registered 64-bit results over a valid/ready handshake. The cipher itself stays inside `tea_interface`; this block only drives its `in`/`mode`/`writekey` and samples its combinational `out`.

## Interface
- `CBC`, default 1: 1 = CBC chaining; 0 = ECB, IV words accepted but ignored.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_data`  in  32  input word; the first word of any group is the most significant.
- `s_kind`  in  2  word type, qualified by `s_valid`: 00 data, 01 key, 10 IV, 11 reserved (word dropped, `err` pulses).
- `s_dec`  in  1  0 encrypt, 1 decrypt; sampled with the first data word of a block.
- `s_valid`  in  1  word present.
- `s_ready`  out  1  word accepted when `s_valid && s_ready`.
- `m_data`  out  64  result block.
- `m_valid`  out  1  result present.
- `m_ready`  in  1  consumer accepts the result.
- `err`  out  1  one-cycle pulse on a protocol violation.
- `tea_in`  out  64  to `tea_interface` `in`.
- `tea_mode`  out  1  to `tea_interface` `mode`.
- `tea_writekey`  out  1  to `tea_interface` `writekey`.
- `tea_out`  in  64  from `tea_interface` `out`; combinational in `tea_in`/`tea_mode`.

## Operation
- **States:** COLLECT, KEY_HI, KEY_LO, CRYPT, OUT. `s_ready` is 1 only in COLLECT.
- **COLLECT:** a word counter and a kind register assemble words.
  - Key: 4 words, first word = K[127:96].
  - IV: 2 words.
  - Data: 2 words.
- **Kind change mid-group:** the partial group is discarded, `err` pulses, and assembly restarts with the new word as word 0.
- **Key complete** → KEY_HI: `tea_writekey`=1, `tea_in`=K[127:64].
  - Next state KEY_LO: `tea_writekey`=0, `tea_in`=K[63:0].
  - Then COLLECT. Set `key_ok`=1 and `chain`=`iv`.
- **IV complete:** `iv` and `chain` ← the IV block, in the acceptance cycle of the second word. Stay in COLLECT.
- **Data complete without key:** if `key_ok`=0, the block is dropped, `err` pulses, and the state stays COLLECT.
- **Data complete with key** → CRYPT (one cycle), `tea_mode`=`dec`.
  - Encrypt: `tea_in`=blk^chain; result=`tea_out`; chain←`tea_out`.
  - Decrypt: `tea_in`=blk; result=`tea_out`^chain; chain←blk.
  - With `CBC`=0, chain is treated as 0 and is never updated.
  - The result is registered into `m_data`; next state OUT.
- **OUT:** `m_valid`=1. `m_data` holds stable until `m_ready`, then the state returns to COLLECT.
- **Idle drive:** outside KEY_HI/KEY_LO/CRYPT, `tea_in`=0, `tea_writekey`=0, `tea_mode`=0.
- **Unchanged state:** `key_ok` persists until reset. A new key load clears nothing else except resetting `chain` to `iv`.

## Timing
- **Reset (async, `rst_n`=0):**
  - State COLLECT, counter 0.
  - `key_ok`=0, `iv`=0, `chain`=0.
  - `m_data`=0, `m_valid`=0, `err`=0, `tea_*`=0.
  - `s_ready`=1 after release.
- **Reset mid-operation:** any in-flight key, partial group or pending result is lost. `tea_interface` must then be rekeyed.
- **Key load:** accepting the 4th key word at cycle n puts `tea_writekey`=1 in cycle n+1 and the low half in cycle n+2. `s_ready` returns at n+3.
- **Data latency:** accepting the 2nd data word at cycle n gives CRYPT at n+1 and `m_valid`=1 from n+2.
- **Throughput:** minimum 4 cycles per block with `m_ready` held high (2 COLLECT, CRYPT, OUT).
- **Output handshake:** `m_valid` is never deasserted without `m_ready`. `m_valid && m_ready` in OUT means COLLECT on the next cycle.
- **`err` behaviour:** registered, high exactly one cycle per violation, and never blocks the FSM.

## Test plan
- **ECB key + encrypt:**
  - Stimulus: `CBC`=0; key 1234567890abcdeffedcba0987654321 as 4 words; data 12345678, 90abcdef with `s_dec`=0.
  - Response: `tea_writekey` high exactly one cycle with `tea_in`=1234567890abcdef, then fedcba0987654321.
  - Response: `m_data` equals the `tea_out` captured in CRYPT, with `m_valid` exactly 2 cycles after the last word.
- **ECB round trip:** feed that result back with `s_dec`=1 → `m_data`=1234567890abcdef.
- **CBC chaining:**
  - Stimulus: IV 0000000000000000; encrypt 1234567890abcdef twice.
  - Response: block 1 equals the ECB result; block 2 differs.
  - Decrypting both after reloading the IV → two blocks of 1234567890abcdef.
- **Backpressure:** hold `m_ready`=0 for 5 cycles in OUT → `m_data` stable, `s_ready`=0 throughout. Release → exactly one transfer.
- **Protocol errors:**
  - Key word, then data word → one-cycle `err`, partial key discarded.
  - Data block before any key after reset → `err`, no `m_valid`.
- **Async reset in CRYPT:** assert `rst_n`=0 mid-cycle → all outputs 0 immediately, `key_ok` cleared. A subsequent data block raises `err`.
